branch_resolve_ctrl: RTL and testbench

- ID-stage control block, directly downstream of the branch comparator. Consumes CompareResult plus decoded branch and jump flags.
- Resolves branch/jal/jalr in ID: computes the target, drives the PC redirect and the IF/ID flush.
- Detects data hazards on branch/jalr source registers against EX and MEM producers and holds the ID instruction for a counted number of cycles.
- Keeps a redirect statistics counter.

---
 rtl/rv_pipe_pkg.sv | 26 ++
 rtl/branch_hazard_detect.sv | 59 +++++
 rtl/branch_resolve_ctrl.sv | 141 ++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions for the ID-stage branch resolve logic:
// FSM encoding, register index width, branch funct3 codes and stall-length helpers.
package rv_pipe_pkg;

    localparam int REG_W  = 5;
    localparam int NEED_W = 2;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STALL = 2'd1,
        ST_GO    = 2'd2
    } brc_state_e;

    function automatic logic [NEED_W-1:0] max_need(input logic [NEED_W-1:0] a,
                                                   input logic [NEED_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/branch_hazard_detect.sv
// Combinational stall-length computation for a branch/jalr in ID against
// EX and MEM producers. Returns 0 when no hazard exists.
module branch_hazard_detect
    import rv_pipe_pkg::*;
(
    input  logic               id_valid_i,
    input  logic               id_branch_i,
    input  logic               id_jal_i,
    input  logic               id_jalr_i,
    input  logic [REG_W-1:0]   id_rs1_i,
    input  logic [REG_W-1:0]   id_rs2_i,
    input  logic               ex_regwrite_i,
    input  logic               ex_memread_i,
    input  logic [REG_W-1:0]   ex_rd_i,
    input  logic               mem_memread_i,
    input  logic [REG_W-1:0]   mem_rd_i,
    output logic [NEED_W-1:0]  need_o
);

    logic              is_jalr_s;
    logic              is_br_s;
    logic              use_rs1_s;
    logic              use_rs2_s;
    logic              ex_match_s;
    logic              mem_match_s;
    logic [NEED_W-1:0] l_ex_s;
    logic [NEED_W-1:0] l_mem_s;

    // jal outranks jalr which outranks branch when several flags are set
    assign is_jalr_s = id_jalr_i & ~id_jal_i;
    assign is_br_s   = id_branch_i & ~id_jal_i & ~id_jalr_i;
    assign use_rs1_s = id_valid_i & (is_jalr_s | is_br_s) & (id_rs1_i != 5'd0);
    assign use_rs2_s = id_valid_i & is_br_s & (id_rs2_i != 5'd0);

    assign ex_match_s  = (use_rs1_s & (ex_rd_i == id_rs1_i)) |
                         (use_rs2_s & (ex_rd_i == id_rs2_i));
    assign mem_match_s = (use_rs1_s & (mem_rd_i == id_rs1_i)) |
                         (use_rs2_s & (mem_rd_i == id_rs2_i));

    // Per-producer stall lengths and their maximum
    always_comb begin
        l_ex_s  = 2'd0;
        l_mem_s = 2'd0;
        if (ex_match_s && ex_memread_i) begin
            l_ex_s = 2'd2;
        end else if (ex_match_s && ex_regwrite_i) begin
            l_ex_s = 2'd1;
        end else begin
            l_ex_s = 2'd0;
        end
        if (mem_match_s && mem_memread_i) begin
            l_mem_s = 2'd1;
        end else begin
            l_mem_s = 2'd0;
        end
        need_o = max_need(l_ex_s, l_mem_s);
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// ID-stage branch/jal/jalr resolution: target generation, PC redirect and
// IF/ID flush, counted hazard stall FSM and a redirect statistics counter.
module branch_resolve_ctrl
    import rv_pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ID_valid,
    input  logic             ID_branch,
    input  logic             ID_jal,
    input  logic             ID_jalr,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic [XLEN-1:0]  ID_pc,
    input  logic [XLEN-1:0]  ID_imm,
    input  logic [XLEN-1:0]  ID_readdata1,
    input  logic             CompareResult,
    input  logic             EX_regwrite,
    input  logic             EX_memread,
    input  logic [4:0]       EX_rd,
    input  logic             MEM_memread,
    input  logic [4:0]       MEM_rd,
    output logic             PCSrc,
    output logic [XLEN-1:0]  branch_target,
    output logic             IF_ID_flush,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             ID_EX_bubble,
    output logic [CNT_W-1:0] redirect_count
);

    brc_state_e        state_q, state_d;
    logic [NEED_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0]  redirect_count_q;
    logic [NEED_W-1:0] need_s;
    logic              taken_s;
    logic              is_jalr_s;
    logic [XLEN-1:0]   pc_sum_s;
    logic [XLEN-1:0]   jalr_sum_s;

    branch_hazard_detect u_hazard (
        .id_valid_i    (ID_valid),
        .id_branch_i   (ID_branch),
        .id_jal_i      (ID_jal),
        .id_jalr_i     (ID_jalr),
        .id_rs1_i      (ID_rs1),
        .id_rs2_i      (ID_rs2),
        .ex_regwrite_i (EX_regwrite),
        .ex_memread_i  (EX_memread),
        .ex_rd_i       (EX_rd),
        .mem_memread_i (MEM_memread),
        .mem_rd_i      (MEM_rd),
        .need_o        (need_s)
    );

    assign taken_s    = ID_valid & (ID_jal | ID_jalr | (ID_branch & CompareResult));
    assign is_jalr_s  = ID_jalr & ~ID_jal;
    assign pc_sum_s   = ID_pc + ID_imm;
    assign jalr_sum_s = ID_readdata1 + ID_imm;

    assign branch_target  = is_jalr_s ? {jalr_sum_s[XLEN-1:1], 1'b0} : pc_sum_s;
    assign redirect_count = redirect_count_q;

    // Stall FSM next state and pipeline control; reset forces the run-state outputs
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        PCSrc        = 1'b0;
        IF_ID_flush  = 1'b0;
        PC_write     = 1'b1;
        IF_ID_write  = 1'b1;
        ID_EX_bubble = 1'b0;
        if (reset) begin
            state_d = ST_IDLE;
            cnt_d   = 2'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (need_s != 2'd0) begin
                        PC_write     = 1'b0;
                        IF_ID_write  = 1'b0;
                        ID_EX_bubble = 1'b1;
                        cnt_d        = need_s - 2'd1;
                        state_d      = (need_s > 2'd1) ? ST_STALL : ST_GO;
                    end else begin
                        PCSrc       = taken_s;
                        IF_ID_flush = taken_s;
                        state_d     = ST_IDLE;
                    end
                end
                ST_STALL: begin
                    // Hazards are not re-sampled here so a load moving EX->MEM is counted once
                    PC_write     = 1'b0;
                    IF_ID_write  = 1'b0;
                    ID_EX_bubble = 1'b1;
                    cnt_d        = cnt_q - 2'd1;
                    if (cnt_q <= 2'd1) begin
                        state_d = ST_GO;
                    end else begin
                        state_d = ST_STALL;
                    end
                end
                ST_GO: begin
                    PCSrc       = taken_s;
                    IF_ID_flush = taken_s;
                    state_d     = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 2'd0;
                end
            endcase
        end
    end

    // FSM state and stall counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Redirect statistics counter, wraps naturally at all-ones
    always_ff @(posedge clk) begin
        if (reset) begin
            redirect_count_q <= {CNT_W{1'b0}};
        end else if (PCSrc) begin
            redirect_count_q <= redirect_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            redirect_count_q <= redirect_count_q;
        end
    end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed scoreboard bench for branch_resolve_ctrl.
module tb_branch_resolve_ctrl;

    logic        clk;
    logic        reset;
    logic        ID_valid, ID_branch, ID_jal, ID_jalr;
    logic [4:0]  ID_rs1, ID_rs2;
    logic [31:0] ID_pc, ID_imm, ID_readdata1;
    logic        CompareResult;
    logic        EX_regwrite, EX_memread;
    logic [4:0]  EX_rd;
    logic        MEM_memread;
    logic [4:0]  MEM_rd;
    logic        PCSrc;
    logic [31:0] branch_target;
    logic        IF_ID_flush, PC_write, IF_ID_write, ID_EX_bubble;
    logic [31:0] redirect_count;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        string       tag;
        logic        pcsrc;
        logic [31:0] tgt;
        logic        flush;
        logic        pcw;
        logic        ifw;
        logic        bub;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];

    branch_resolve_ctrl #(.XLEN(32), .CNT_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .ID_valid      (ID_valid),
        .ID_branch     (ID_branch),
        .ID_jal        (ID_jal),
        .ID_jalr       (ID_jalr),
        .ID_rs1        (ID_rs1),
        .ID_rs2        (ID_rs2),
        .ID_pc         (ID_pc),
        .ID_imm        (ID_imm),
        .ID_readdata1  (ID_readdata1),
        .CompareResult (CompareResult),
        .EX_regwrite   (EX_regwrite),
        .EX_memread    (EX_memread),
        .EX_rd         (EX_rd),
        .MEM_memread   (MEM_memread),
        .MEM_rd        (MEM_rd),
        .PCSrc         (PCSrc),
        .branch_target (branch_target),
        .IF_ID_flush   (IF_ID_flush),
        .PC_write      (PC_write),
        .IF_ID_write   (IF_ID_write),
        .ID_EX_bubble  (ID_EX_bubble),
        .redirect_count(redirect_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        ID_valid = 1'b0; ID_branch = 1'b0; ID_jal = 1'b0; ID_jalr = 1'b0;
        ID_rs1 = 5'd0; ID_rs2 = 5'd0;
        ID_pc = 32'h0; ID_imm = 32'h0; ID_readdata1 = 32'h0;
        CompareResult = 1'b0;
        EX_regwrite = 1'b0; EX_memread = 1'b0; EX_rd = 5'd0;
        MEM_memread = 1'b0; MEM_rd = 5'd0;
    endtask

    task automatic push(input string tag, input logic pcsrc, input logic [31:0] tgt,
                        input logic flush, input logic pcw, input logic ifw,
                        input logic bub, input logic [31:0] cnt);
        exp_t e;
        e.tag = tag; e.pcsrc = pcsrc; e.tgt = tgt; e.flush = flush;
        e.pcw = pcw; e.ifw = ifw; e.bub = bub; e.cnt = cnt;
        sb.push_back(e);
    endtask

    // stall-cycle shorthand
    task automatic push_stall(input string tag, input logic [31:0] cnt);
        push(tag, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, cnt);
    endtask

    task automatic chk(input string tag, input string field,
                       input logic [31:0] obs, input logic [31:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, expv);
    endtask

    // compare at negedge, then advance past the next rising edge
    task automatic check_cycle();
        exp_t e;
        @(negedge clk);
        if (sb.size() == 0) begin
            total_cnt++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            chk(e.tag, "PCSrc",          {31'd0, PCSrc},        {31'd0, e.pcsrc});
            chk(e.tag, "IF_ID_flush",    {31'd0, IF_ID_flush},  {31'd0, e.flush});
            chk(e.tag, "PC_write",       {31'd0, PC_write},     {31'd0, e.pcw});
            chk(e.tag, "IF_ID_write",    {31'd0, IF_ID_write},  {31'd0, e.ifw});
            chk(e.tag, "ID_EX_bubble",   {31'd0, ID_EX_bubble}, {31'd0, e.bub});
            chk(e.tag, "redirect_count", redirect_count,        e.cnt);
            if (e.pcsrc === 1'b1) begin
                chk(e.tag, "branch_target", branch_target, e.tgt);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        @(posedge clk);
        #1;
        push("reset", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        check_cycle();
        reset = 1'b0;

        // beq taken, no producers
        clear_inputs();
        ID_valid = 1'b1; ID_branch = 1'b1; ID_rs1 = 5'd5; ID_rs2 = 5'd6;
        CompareResult = 1'b1; ID_pc = 32'h100; ID_imm = 32'h20;
        push("beq", 1'b1, 32'h120, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
        check_cycle();
        clear_inputs();
        push("idle1", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd1);
        check_cycle();

        // bne x7 with EX load rd=7: two stalls, then GO while load still in MEM
        ID_valid = 1'b1; ID_branch = 1'b1; ID_rs1 = 5'd7; ID_rs2 = 5'd8;
        CompareResult = 1'b1; ID_pc = 32'h200; ID_imm = 32'h40;
        EX_regwrite = 1'b1; EX_memread = 1'b1; EX_rd = 5'd7;
        push_stall("bne_ld_s1", 32'd1);
        check_cycle();
        EX_regwrite = 1'b0; EX_memread = 1'b0; EX_rd = 5'd0;
        MEM_memread = 1'b1; MEM_rd = 5'd7;
        push_stall("bne_ld_s2", 32'd1);
        check_cycle();
        push("bne_ld_go", 1'b1, 32'h240, 1'b1, 1'b1, 1'b1, 1'b0, 32'd1);
        check_cycle();

        // blt x3 with EX ALU rd=3: one stall then not-taken resolve
        clear_inputs();
        ID_valid = 1'b1; ID_branch = 1'b1; ID_rs1 = 5'd3; ID_rs2 = 5'd4;
        CompareResult = 1'b0; ID_pc = 32'h280; ID_imm = 32'h10;
        EX_regwrite = 1'b1; EX_rd = 5'd3;
        push_stall("blt_alu_s1", 32'd2);
        check_cycle();
        EX_regwrite = 1'b0; EX_rd = 5'd0;
        push("blt_alu_go", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd2);
        check_cycle();

        // blt on x0 with EX load rd=0: no stall, negative offset
        clear_inputs();
        ID_valid = 1'b1; ID_branch = 1'b1; ID_rs1 = 5'd0; ID_rs2 = 5'd9;
        CompareResult = 1'b1; ID_pc = 32'h300; ID_imm = 32'hFFFF_FFF0;
        EX_regwrite = 1'b1; EX_memread = 1'b1; EX_rd = 5'd0;
        push("blt_x0", 1'b1, 32'h2F0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd2);
        check_cycle();

        // jalr with odd sum, bit0 cleared
        clear_inputs();
        ID_valid = 1'b1; ID_jalr = 1'b1; ID_rs1 = 5'd10;
        ID_readdata1 = 32'h1003; ID_imm = 32'h4; ID_pc = 32'h500;
        push("jalr", 1'b1, 32'h1006, 1'b1, 1'b1, 1'b1, 1'b0, 32'd3);
        check_cycle();

        // jal wraps; a load on its rs1 field must not stall it
        clear_inputs();
        ID_valid = 1'b1; ID_jal = 1'b1; ID_rs1 = 5'd1;
        ID_pc = 32'hFFFF_FFF0; ID_imm = 32'h20;
        EX_regwrite = 1'b1; EX_memread = 1'b1; EX_rd = 5'd1;
        push("jal_wrap", 1'b1, 32'h10, 1'b1, 1'b1, 1'b1, 1'b0, 32'd4);
        check_cycle();

        // bubble in ID: no stall, no redirect despite hazard and compare
        clear_inputs();
        ID_valid = 1'b0; ID_branch = 1'b1; ID_rs1 = 5'd7; CompareResult = 1'b1;
        EX_memread = 1'b1; EX_regwrite = 1'b1; EX_rd = 5'd7;
        push("invalid", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd5);
        check_cycle();

        // all three flags: jal wins, target from PC
        clear_inputs();
        ID_valid = 1'b1; ID_jal = 1'b1; ID_jalr = 1'b1; ID_branch = 1'b1;
        ID_pc = 32'h400; ID_imm = 32'h8; ID_readdata1 = 32'h5000; CompareResult = 1'b1;
        push("priority", 1'b1, 32'h408, 1'b1, 1'b1, 1'b1, 1'b0, 32'd5);
        check_cycle();

        // ID_valid drops during a stall: count completes, GO does not redirect
        clear_inputs();
        ID_valid = 1'b1; ID_branch = 1'b1; ID_rs1 = 5'd7; ID_rs2 = 5'd2;
        CompareResult = 1'b1; ID_pc = 32'h600; ID_imm = 32'h4;
        EX_regwrite = 1'b1; EX_memread = 1'b1; EX_rd = 5'd7;
        push_stall("vdrop_s1", 32'd6);
        check_cycle();
        ID_valid = 1'b0; EX_regwrite = 1'b0; EX_memread = 1'b0; EX_rd = 5'd0;
        push_stall("vdrop_s2", 32'd6);
        check_cycle();
        push("vdrop_go", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd6);
        check_cycle();

        // reset asserted in STALL: outputs released, then IDLE with count 0
        clear_inputs();
        ID_valid = 1'b1; ID_branch = 1'b1; ID_rs1 = 5'd7; ID_rs2 = 5'd2;
        CompareResult = 1'b1; ID_pc = 32'h700; ID_imm = 32'h4;
        EX_regwrite = 1'b1; EX_memread = 1'b1; EX_rd = 5'd7;
        push_stall("rst_s1", 32'd6);
        check_cycle();
        reset = 1'b1;
        push("rst_cycle", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd6);
        check_cycle();
        reset = 1'b0;
        clear_inputs();
        ID_valid = 1'b1; ID_branch = 1'b1; ID_rs1 = 5'd7; CompareResult = 1'b0;
        push("rst_after", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        check_cycle();
        CompareResult = 1'b1; ID_pc = 32'h800; ID_imm = 32'hC;
        push("rst_taken", 1'b1, 32'h80C, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
        check_cycle();
        clear_inputs();
        push("rst_cnt", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd1);
        check_cycle();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
